mega_debug_burst_ctl: RTL and testbench

//  Burst sequencer for the ATMEGA debug memory port. Accepts one command (start addr, byte count, direction)

---
 rtl/mega_debug_burst_ctl.sv | 187 ++++++++++++++++++
 tb/tb_mega_debug_burst_ctl.sv | 408 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mega_debug_burst_ctl.sv
// Burst sequencer for the ATMEGA debug memory port.
// Takes one command (start address, byte count, direction) from the debug host
// front-end and turns it into single-byte deb_* strobes with auto-increment.
// Write bytes arrive over a valid/ready stream and read bytes leave over one.
// In TEXT, write bursts must cover whole words, starting on an even address.
// This lets the memory selector see the even byte and then the odd byte, and
// commit each 16-bit word as a unit.
//
// Handshake rule, identical on cmd_*, wdat_* and rdat_*: a transfer happens on
// the rising edge where valid and ready are both 1. A producer may not make
// valid depend on ready. Ready here is a pure function of registered state.
module mega_debug_burst_ctl #(
    parameter int ADDR_W      = 25,
    parameter int LEN_W       = 16,
    parameter int TEXT_LENGTH = 'h020000,
    parameter int RD_LATENCY  = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [LEN_W-1:0]  cmd_len,
    input  logic              cmd_wr,
    input  logic              abort,
    input  logic              wdat_valid,
    output logic              wdat_ready,
    input  logic [7:0]        wdat,
    output logic              rdat_valid,
    input  logic              rdat_ready,
    output logic [7:0]        rdat,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [ADDR_W-1:0] deb_addr,
    output logic              deb_en,
    output logic              deb_wr,
    output logic              deb_rd,
    output logic [7:0]        deb_wdat,
    input  logic [7:0]        deb_rdat
);

    // FSM encoding; "state" is the signal to probe when debugging.
    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_WR       = 3'd1;
    localparam logic [2:0] S_RD_ISSUE = 3'd2;
    localparam logic [2:0] S_RD_WAIT  = 3'd3;
    localparam logic [2:0] S_RD_HOLD  = 3'd4;

    // One bit wider than an address, so the end of a burst never wraps.
    localparam logic [ADDR_W:0] ADDR_SPAN = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0] TEXT_LIM  = (ADDR_W+1)'(TEXT_LENGTH);
    localparam logic [1:0]      LAT_LOAD  = 2'(RD_LATENCY - 1);

    logic [2:0]        state;
    logic [ADDR_W-1:0] addr;
    logic [LEN_W-1:0]  rem;
    logic [1:0]        lat_cnt;
    logic [7:0]        rdat_q;
    logic              done_q;
    logic              err_q;
    logic              live;

    logic [ADDR_W:0]   cmd_end;
    logic              in_text;
    logic              reject;
    logic              cmd_fire;
    logic              wr_fire;
    logic              rd_fire;
    logic              last_byte;

    // Command legality is checked on the accept edge, using exclusive end address.
    always_comb begin
        cmd_end = {1'b0, cmd_addr} + (ADDR_W+1)'(cmd_len);
        in_text = {1'b0, cmd_addr} < TEXT_LIM;
        reject  = 1'b0;
        if (cmd_len == '0) begin
            reject = 1'b1;
        end
        if (cmd_end > ADDR_SPAN) begin
            reject = 1'b1;
        end
        // TEXT writes must be whole, even-aligned words that end inside TEXT.
        if (cmd_wr && in_text && (cmd_addr[0] || cmd_len[0] || (cmd_end > TEXT_LIM))) begin
            reject = 1'b1;
        end
    end

    // Handshake qualifiers. These are all decoded from registered state.
    always_comb begin
        // No command is taken during the first cycle after reset or during the done pulse.
        cmd_ready  = live && (state == S_IDLE) && !done_q;
        cmd_fire   = cmd_valid && cmd_ready;
        wdat_ready = (state == S_WR);
        wr_fire    = wdat_ready && wdat_valid;
        rdat_valid = (state == S_RD_HOLD);
        rd_fire    = rdat_valid && rdat_ready;
        last_byte  = (rem == LEN_W'(1));
    end

    // Memory-side strobes. Address and data are zero when no access is in progress.
    always_comb begin
        deb_wr   = wr_fire;
        deb_rd   = (state == S_RD_ISSUE);
        deb_en   = deb_wr || deb_rd;
        deb_addr = deb_en ? addr : '0;
        deb_wdat = wr_fire ? wdat : 8'h00;
        busy     = (state != S_IDLE);
        done     = done_q;
        err      = err_q;
        rdat     = rdat_q;
    end

    // Burst sequencer: state, address/remaining counters, read capture and pulses.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state   <= S_IDLE;
            addr    <= '0;
            rem     <= '0;
            lat_cnt <= 2'd0;
            rdat_q  <= 8'h00;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            live    <= 1'b0;
        end else begin
            live   <= 1'b1;
            done_q <= 1'b0;
            err_q  <= 1'b0;
            if ((state != S_IDLE) && abort) begin
                // Abort stops the burst silently. A half-written TEXT word stays uncommitted.
                state <= S_IDLE;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (cmd_fire) begin
                            if (reject) begin
                                err_q <= 1'b1;
                            end else begin
                                addr  <= cmd_addr;
                                rem   <= cmd_len;
                                state <= cmd_wr ? S_WR : S_RD_ISSUE;
                            end
                        end
                    end
                    S_WR: begin
                        if (wr_fire) begin
                            addr <= addr + ADDR_W'(1);
                            rem  <= rem - LEN_W'(1);
                            if (last_byte) begin
                                state  <= S_IDLE;
                                done_q <= 1'b1;
                            end
                        end
                    end
                    S_RD_ISSUE: begin
                        lat_cnt <= LAT_LOAD;
                        state   <= S_RD_WAIT;
                    end
                    S_RD_WAIT: begin
                        if (lat_cnt == 2'd0) begin
                            rdat_q <= deb_rdat;
                            state  <= S_RD_HOLD;
                        end else begin
                            lat_cnt <= lat_cnt - 2'd1;
                        end
                    end
                    S_RD_HOLD: begin
                        if (rd_fire) begin
                            addr <= addr + ADDR_W'(1);
                            rem  <= rem - LEN_W'(1);
                            if (last_byte) begin
                                state  <= S_IDLE;
                                done_q <= 1'b1;
                            end else begin
                                state <= S_RD_ISSUE;
                            end
                        end
                    end
                    default: begin
                        state <= S_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_mega_debug_burst_ctl.sv
// Self-checking bench for mega_debug_burst_ctl.
// It contains a byte-pattern memory model with a one-cycle read latency.
// A negedge monitor records every strobe and pulse, and a reference model derives
// the expected access lists and the accept/reject result for each command.
module tb_mega_debug_burst_ctl;

    localparam int W = 33;  // {addr[24:0], byte}
    localparam longint TEXT_LEN = 'h020000;

    logic        clk;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [24:0] cmd_addr;
    logic [15:0] cmd_len;
    logic        cmd_wr;
    logic        abort;
    logic        wdat_valid;
    logic        wdat_ready;
    logic [7:0]  wdat;
    logic        rdat_valid;
    logic        rdat_ready;
    logic [7:0]  rdat;
    logic        busy;
    logic        done;
    logic        err;
    logic [24:0] deb_addr;
    logic        deb_en;
    logic        deb_wr;
    logic        deb_rd;
    logic [7:0]  deb_wdat;
    logic [7:0]  deb_rdat;

    mega_debug_burst_ctl dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr),
        .cmd_len(cmd_len), .cmd_wr(cmd_wr), .abort(abort),
        .wdat_valid(wdat_valid), .wdat_ready(wdat_ready), .wdat(wdat),
        .rdat_valid(rdat_valid), .rdat_ready(rdat_ready), .rdat(rdat),
        .busy(busy), .done(done), .err(err),
        .deb_addr(deb_addr), .deb_en(deb_en), .deb_wr(deb_wr), .deb_rd(deb_rd),
        .deb_wdat(deb_wdat), .deb_rdat(deb_rdat)
    );

    // ---------------- clock / reset / memory model ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [7:0] mem_byte(input logic [24:0] a);
        return a[7:0] ^ a[15:8] ^ {3'b000, a[24:20]} ^ 8'h5A;
    endfunction

    // Read data appears exactly one cycle after the strobe cycle and is zero otherwise.
    logic [7:0] rd_pipe = 8'h00;
    always @(posedge clk) rd_pipe <= (deb_en && deb_rd) ? mem_byte(deb_addr) : 8'h00;
    assign deb_rdat = rd_pipe;

    // ---------------- monitor ----------------
    logic [W-1:0] wr_log[$];
    logic [24:0]  rd_addr_log[$];
    logic [7:0]   rd_out_log[$];
    int           wr_cyc[$];
    int           rd_cyc[$];
    int done_cnt = 0, err_cnt = 0, done_cyc = 0, viol = 0, ready_bad = 0;

    always @(negedge clk) begin
        if (rst) begin
            if (deb_en && deb_wr) begin
                wr_log.push_back({deb_addr, deb_wdat});
                wr_cyc.push_back(cyc);
            end
            if (deb_en && deb_rd) begin
                rd_addr_log.push_back(deb_addr);
                rd_cyc.push_back(cyc);
            end
            if (rdat_valid && rdat_ready) rd_out_log.push_back(rdat);
            if (done) begin
                done_cnt <= done_cnt + 1;
                done_cyc <= cyc;
                if (cmd_ready) ready_bad <= ready_bad + 1;
            end
            if (err) err_cnt <= err_cnt + 1;
            if ((deb_wr && deb_rd) || (deb_en != (deb_wr || deb_rd))) viol <= viol + 1;
        end
    end

    // ---------------- scoreboard ----------------
    logic [W-1:0] exp_q[$];
    logic [7:0]   wbuf [16];
    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Command legality, taken directly from the rules with plain integer arithmetic.
    function automatic bit model_reject(input longint a, input longint l, input bit w);
        longint e;
        e = a + l;
        if (l == 0) return 1'b1;
        if (e > (longint'(1) << 25)) return 1'b1;
        if (w && (a < TEXT_LEN) && ((a % 2) == 1 || (l % 2) == 1 || e > TEXT_LEN)) return 1'b1;
        return 1'b0;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Called just after a posedge; returns just after the accept edge.
    task automatic issue_cmd(input logic [24:0] a, input logic [15:0] l, input logic w, output bit ok);
        cmd_addr  = a;
        cmd_len   = l;
        cmd_wr    = w;
        cmd_valid = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (cmd_ready) begin
                ok = 1'b1;
                break;
            end
        end
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_done(input int d0);
        int to;
        to = 0;
        while (done_cnt == d0 && to < 200) begin
            @(posedge clk);
            #1;
            to++;
        end
    endtask

    task automatic clear_logs();
        wr_log.delete();
        rd_addr_log.delete();
        rd_out_log.delete();
        wr_cyc.delete();
        rd_cyc.delete();
    endtask

    // Runs one complete command, then compares the observed traffic with the model.
    task automatic do_burst(input logic [24:0] a, input logic [15:0] l, input logic w,
                            input bit exp_err, input bit rnd, input string name);
        bit ok;
        int d0, e0, to;
        logic [24:0] ai;
        logic [W-1:0] act, expv;
        clear_logs();
        d0 = done_cnt;
        e0 = err_cnt;
        issue_cmd(a, l, w, ok);
        check({name, "_accept"}, ok, 1);
        if (!ok) return;
        if (exp_err) begin
            tick(4);
        end else if (w) begin
            for (int i = 0; i < int'(l); i++) begin
                if (rnd) tick($urandom_range(0, 2));
                wdat = wbuf[i];
                wdat_valid = 1'b1;
                tick(1);
                wdat_valid = 1'b0;
                wdat = 8'h00;
            end
            wait_done(d0);
        end else begin
            rdat_ready = 1'b1;
            to = 0;
            while (done_cnt == d0 && to < 300) begin
                tick(1);
                to++;
                if (rnd) rdat_ready = ($urandom_range(0, 3) != 0);
            end
            rdat_ready = 1'b0;
        end
        tick(1);
        check({name, "_err"}, err_cnt - e0, exp_err ? 1 : 0);
        check({name, "_done"}, done_cnt - d0, exp_err ? 0 : 1);
        // writes
        exp_q.delete();
        if (!exp_err && w) begin
            for (int i = 0; i < int'(l); i++) begin
                ai = a + 25'(i);
                exp_q.push_back({ai, wbuf[i]});
            end
        end
        check({name, "_nwr"}, wr_log.size(), exp_q.size());
        while (exp_q.size() > 0 && wr_log.size() > 0) begin
            act  = wr_log.pop_front();
            expv = exp_q.pop_front();
            check({name, "_wr"}, act, expv);
        end
        // reads
        exp_q.delete();
        if (!exp_err && !w) begin
            for (int i = 0; i < int'(l); i++) begin
                ai = a + 25'(i);
                exp_q.push_back({ai, mem_byte(ai)});
            end
        end
        check({name, "_nrd"}, rd_addr_log.size(), exp_q.size());
        check({name, "_nrdo"}, rd_out_log.size(), exp_q.size());
        while (exp_q.size() > 0 && rd_addr_log.size() > 0 && rd_out_log.size() > 0) begin
            ai   = rd_addr_log.pop_front();
            act  = {ai, rd_out_log.pop_front()};
            expv = exp_q.pop_front();
            check({name, "_rd"}, act, expv);
        end
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic [24:0] addr;
        logic [15:0] len;
        logic        wr;
        logic        exp_err;
    } vec_t;

    vec_t vecs[11];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;
        int d0, e0, to, bad;

        vecs[0]  = '{25'h0000011, 16'd2, 1'b1, 1'b1};  // odd TEXT write start
        vecs[1]  = '{25'h001FFFE, 16'd4, 1'b1, 1'b1};  // crosses TEXT end
        vecs[2]  = '{25'h0000010, 16'd0, 1'b0, 1'b1};  // zero length
        vecs[3]  = '{25'h1FFFFFF, 16'd2, 1'b0, 1'b1};  // past top of map
        vecs[4]  = '{25'h1FFFFFF, 16'd1, 1'b0, 1'b0};  // ends exactly at top
        vecs[5]  = '{25'h0000020, 16'd3, 1'b1, 1'b1};  // odd TEXT write length
        vecs[6]  = '{25'h001FFFE, 16'd2, 1'b1, 1'b0};  // ends exactly at TEXT end
        vecs[7]  = '{25'h0000010, 16'd3, 1'b0, 1'b0};  // TEXT read, odd is fine
        vecs[8]  = '{25'h001FFFF, 16'd3, 1'b1, 1'b1};  // odd TEXT write start
        vecs[9]  = '{25'h0020000, 16'd3, 1'b1, 1'b0};  // just above TEXT
        vecs[10] = '{25'h0800001, 16'd1, 1'b1, 1'b0};  // RAM single byte

        rst = 1'b0; cmd_valid = 1'b0; cmd_addr = '0; cmd_len = '0; cmd_wr = 1'b0;
        abort = 1'b0; wdat_valid = 1'b0; wdat = 8'h00; rdat_ready = 1'b0;

        // reset
        tick(3);
        check("rst_ctl", {cmd_ready, wdat_ready, rdat_valid, busy, done, err, deb_en, deb_wr, deb_rd}, 0);
        check("rst_data", {rdat, deb_wdat, deb_addr}, 0);
        rst = 1'b1;
        check("rst_ready_low", cmd_ready, 0);
        tick(1);
        check("rst_ready_up", cmd_ready, 1);

        // 1) RAM write, back-to-back, timing
        wbuf[0] = 8'h11; wbuf[1] = 8'h22; wbuf[2] = 8'h33; wbuf[3] = 8'h44;
        do_burst(25'h0800100, 16'd4, 1'b1, 1'b0, 1'b0, "t1");
        check("t1_ncyc", wr_cyc.size(), 4);
        if (wr_cyc.size() == 4) begin
            check("t1_consecutive", wr_cyc[3] - wr_cyc[0], 3);
            check("t1_done_time", done_cyc, wr_cyc[3] + 1);
        end

        // 2) TEXT read, one byte every 3 clocks
        do_burst(25'h0000010, 16'd3, 1'b0, 1'b0, 1'b0, "t2");
        check("t2_ncyc", rd_cyc.size(), 3);
        if (rd_cyc.size() == 3) begin
            check("t2_gap0", rd_cyc[1] - rd_cyc[0], 3);
            check("t2_gap1", rd_cyc[2] - rd_cyc[1], 3);
            check("t2_done_time", done_cyc, rd_cyc[2] + 3);
        end

        // 3) + table of accept/reject vectors
        for (int v = 0; v < 11; v++) begin
            for (int i = 0; i < 16; i++) wbuf[i] = 8'($urandom);
            do_burst(vecs[v].addr, vecs[v].len, vecs[v].wr, vecs[v].exp_err, 1'b0, "vec");
        end

        // 4) read back-pressure: rdat held, no second strobe
        clear_logs();
        d0 = done_cnt;
        rdat_ready = 1'b0;
        issue_cmd(25'h0800300, 16'd2, 1'b0, ok);
        check("t4_accept", ok, 1);
        to = 0;
        while (!rdat_valid && to < 20) begin
            tick(1);
            to++;
        end
        check("t4_valid", rdat_valid, 1);
        bad = 0;
        repeat (10) begin
            tick(1);
            if (!rdat_valid || rdat !== mem_byte(25'h0800300)) bad++;
        end
        check("t4_hold_stable", bad, 0);
        check("t4_one_strobe", rd_cyc.size(), 1);
        rdat_ready = 1'b1;
        wait_done(d0);
        rdat_ready = 1'b0;
        check("t4_done", done_cnt - d0, 1);
        check("t4_strobes", rd_cyc.size(), 2);
        check("t4_nout", rd_out_log.size(), 2);
        if (rd_out_log.size() == 2) check("t4_byte1", rd_out_log[1], mem_byte(25'h0800301));

        // 5) abort after 3 of 8 write bytes
        clear_logs();
        d0 = done_cnt;
        e0 = err_cnt;
        issue_cmd(25'h0800200, 16'd8, 1'b1, ok);
        check("t5_accept", ok, 1);
        for (int i = 0; i < 3; i++) begin
            wdat = 8'(8'hA0 + i);
            wdat_valid = 1'b1;
            tick(1);
        end
        wdat_valid = 1'b0;
        abort = 1'b1;
        tick(1);
        abort = 1'b0;
        check("t5_idle", {busy, wdat_ready, deb_en}, 0);
        check("t5_ready_next", cmd_ready, 1);
        tick(3);
        check("t5_nwr", wr_log.size(), 3);
        check("t5_no_done", done_cnt - d0, 0);
        check("t5_no_err", err_cnt - e0, 0);
        do_burst(25'h0800200, 16'd1, 1'b0, 1'b0, 1'b0, "t5_after");

        // abort together with cmd_valid in IDLE is ignored
        d0 = done_cnt;
        abort = 1'b1;
        issue_cmd(25'h0800010, 16'd2, 1'b0, ok);
        abort = 1'b0;
        check("abi_accept", ok, 1);
        check("abi_busy", busy, 1);
        rdat_ready = 1'b1;
        wait_done(d0);
        rdat_ready = 1'b0;
        check("abi_done", done_cnt - d0, 1);

        // randomized commands against the reference model
        for (int k = 0; k < 24; k++) begin
            logic [24:0] a;
            int l;
            bit w;
            case ($urandom_range(0, 3))
                0:       a = 25'($urandom_range(0, 'h1FFFF));
                1:       a = 25'('h1FFF8 + $urandom_range(0, 15));
                2:       a = 25'('h800000 + $urandom_range(0, 'hFFFF));
                default: a = 25'('h1FFFFF8 + $urandom_range(0, 7));
            endcase
            l = $urandom_range(0, 6);
            w = 1'($urandom_range(0, 1));
            if (w && a < 25'h20000 && $urandom_range(0, 1) == 1) begin
                a[0] = 1'b0;
                l = l & ~1;
            end
            for (int i = 0; i < 16; i++) wbuf[i] = 8'($urandom);
            do_burst(a, 16'(l), w, model_reject(longint'(a), longint'(l), w), 1'b1, "rnd");
        end

        // 6) reset in the middle of a read
        d0 = done_cnt;
        rdat_ready = 1'b0;
        issue_cmd(25'h0800400, 16'd3, 1'b0, ok);
        check("t6_accept", ok, 1);
        to = 0;
        while (!rdat_valid && to < 20) begin
            tick(1);
            to++;
        end
        rst = 1'b0;
        tick(1);
        check("t6_ctl", {cmd_ready, wdat_ready, rdat_valid, busy, done, err, deb_en, deb_wr, deb_rd}, 0);
        check("t6_data", {rdat, deb_wdat, deb_addr}, 0);
        rst = 1'b1;
        tick(1);
        check("t6_ready", cmd_ready, 1);
        tick(2);
        check("t6_no_done", done_cnt - d0, 0);

        check("strobe_rules", viol, 0);
        check("ready_in_done", ready_bad, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
